// File: rtl/eth_pkt_dispatcher.sv
// rtl/eth_pkt_dispatcher.sv - offers each Rx packet to a chain of decoders and forwards the owner's Tx writes
// Optional watchdog on a silent decoder: define ETH_DISP_TIMEOUT_EN.
module eth_pkt_dispatcher #(
  parameter int N_DEC       = 3,
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Rx_Parcer_RQ,
  output logic [ADDR_W-1:0]       Rx_Addr_o,
  output logic [N_DEC-1:0]        Dec_Start,
  input  logic [N_DEC*ADDR_W-1:0] Dec_Rx_Addr,
  input  logic [N_DEC*ADDR_W-1:0] Dec_Tx_Addr,
  input  logic [N_DEC*DATA_W-1:0] Dec_Tx_Data,
  input  logic [N_DEC-1:0]        Dec_Tx_Strobe,
  input  logic [N_DEC-1:0]        Dec_Next,
  input  logic [N_DEC-1:0]        Dec_Done,
  input  logic [N_DEC-1:0]        Dec_Err,
  output logic [ADDR_W-1:0]       Tx_Addr,
  output logic [DATA_W-1:0]       Tx_Data,
  output logic                    Tx_Word_Strobe,
  output logic                    Progress_Flag,
  output logic                    Tx_Start,
  output logic                    CycleEndErr,
  output logic                    Timeout_Err,
  output logic [2:0]              Active_Chan,
  output logic [15:0]             Pkt_Cnt,
  output logic [15:0]             Err_Cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_RUN     = 3'd2,
    S_END_OK  = 3'd3,
    S_END_ERR = 3'd4
  } state_t;

  if (N_DEC < 2 || N_DEC > 8 || TIMEOUT_CYC < 16 ||
      (TIMEOUT_CYC & (TIMEOUT_CYC - 1)) != 0) begin : g_param_err
    $error("eth_pkt_dispatcher: illegal parameter value");
  end

  state_t              r_state;
  state_t              w_state_nx;
  logic [2:0]          r_chan;
  logic [2:0]          w_chan_nx;

  logic [N_DEC-1:0]    r_dec_start;
  logic [ADDR_W-1:0]   r_tx_addr;
  logic [DATA_W-1:0]   r_tx_data;
  logic                r_tx_strobe;
  logic                r_progress;
  logic                r_tx_start;
  logic                r_cyc_err;
  logic [15:0]         r_pkt_cnt;
  logic [15:0]         r_err_cnt;

  logic [N_DEC-1:0]    w_dec_start_nx;
  logic [ADDR_W-1:0]   w_tx_addr_nx;
  logic [DATA_W-1:0]   w_tx_data_nx;
  logic                w_tx_strobe_nx;
  logic [15:0]         w_pkt_cnt_nx;
  logic [15:0]         w_err_cnt_nx;

  logic [ADDR_W-1:0]   w_rx_addr_sel;
  logic [ADDR_W-1:0]   w_tx_addr_sel;
  logic [DATA_W-1:0]   w_tx_data_sel;
  logic                w_tx_strobe_sel;
  logic                w_next;
  logic                w_done;
  logic                w_err;
  logic                w_busy;

`ifdef ETH_DISP_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC);
  logic [WD_W-1:0]     r_wd;
  logic                r_timeout_err;
  logic                w_timeout;
`endif

  // Only the channel holding the token is ever looked at.
  always_comb begin
    w_rx_addr_sel   = '0;
    w_tx_addr_sel   = '0;
    w_tx_data_sel   = '0;
    w_tx_strobe_sel = 1'b0;
    w_next          = 1'b0;
    w_done          = 1'b0;
    w_err           = 1'b0;
    for (int k = 0; k < N_DEC; k++) begin
      if (r_chan == 3'(k)) begin
        w_rx_addr_sel   = Dec_Rx_Addr[k*ADDR_W +: ADDR_W];
        w_tx_addr_sel   = Dec_Tx_Addr[k*ADDR_W +: ADDR_W];
        w_tx_data_sel   = Dec_Tx_Data[k*DATA_W +: DATA_W];
        w_tx_strobe_sel = Dec_Tx_Strobe[k];
        w_next          = Dec_Next[k];
        w_done          = Dec_Done[k];
        w_err           = Dec_Err[k];
      end
    end
  end

  assign w_busy    = (r_state == S_START) || (r_state == S_RUN);
  assign Rx_Addr_o = w_busy ? w_rx_addr_sel : '0;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state <= S_IDLE;
      r_chan  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_chan  <= w_chan_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_chan_nx  = r_chan;
`ifdef ETH_DISP_TIMEOUT_EN
    w_timeout  = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (Rx_Parcer_RQ) begin
          w_state_nx = S_START;
          w_chan_nx  = '0;
        end
      end
      S_START: w_state_nx = S_RUN;
      S_RUN: begin
        if (w_err) begin
          w_state_nx = S_END_ERR;
        end else if (w_done) begin
          w_state_nx = S_END_OK;
        end else if (w_next) begin
          // The last channel passing means nobody owns the packet.
          if (r_chan == 3'(N_DEC - 1)) begin
            w_state_nx = S_END_ERR;
          end else begin
            w_state_nx = S_START;
            w_chan_nx  = r_chan + 3'd1;
          end
        end
`ifdef ETH_DISP_TIMEOUT_EN
        else if (r_wd == WD_W'(TIMEOUT_CYC - 1)) begin
          w_state_nx = S_END_ERR;
          w_timeout  = 1'b1;
        end
`endif
      end
      S_END_OK:  w_state_nx = S_IDLE;
      S_END_ERR: w_state_nx = S_IDLE;
      default:   w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    w_dec_start_nx = '0;
    if (w_state_nx == S_START) begin
      w_dec_start_nx = N_DEC'(1) << w_chan_nx;
    end
    w_tx_addr_nx   = w_busy ? w_tx_addr_sel : '0;
    w_tx_data_nx   = w_busy ? w_tx_data_sel : '0;
    w_tx_strobe_nx = w_busy & w_tx_strobe_sel;
    w_pkt_cnt_nx   = r_pkt_cnt;
    w_err_cnt_nx   = r_err_cnt;
    if (w_state_nx == S_END_OK && r_pkt_cnt != 16'hFFFF) begin
      w_pkt_cnt_nx = r_pkt_cnt + 16'd1;
    end
    if (w_state_nx == S_END_ERR && r_err_cnt != 16'hFFFF) begin
      w_err_cnt_nx = r_err_cnt + 16'd1;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_dec_start <= '0;
      r_tx_addr   <= '0;
      r_tx_data   <= '0;
      r_tx_strobe <= 1'b0;
      r_progress  <= 1'b0;
      r_tx_start  <= 1'b0;
      r_cyc_err   <= 1'b0;
      r_pkt_cnt   <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_dec_start <= w_dec_start_nx;
      r_tx_addr   <= w_tx_addr_nx;
      r_tx_data   <= w_tx_data_nx;
      r_tx_strobe <= w_tx_strobe_nx;
      r_progress  <= (w_state_nx != S_IDLE);
      r_tx_start  <= (w_state_nx == S_END_OK);
      r_cyc_err   <= (w_state_nx == S_END_ERR);
      r_pkt_cnt   <= w_pkt_cnt_nx;
      r_err_cnt   <= w_err_cnt_nx;
    end
  end

`ifdef ETH_DISP_TIMEOUT_EN
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_wd          <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == S_START) begin
        r_wd <= '0;
      end else if (r_state == S_RUN) begin
        r_wd <= r_wd + 1'b1;
      end
      r_timeout_err <= w_timeout;
    end
  end

  assign Timeout_Err = r_timeout_err;
`else
  assign Timeout_Err = 1'b0;
`endif

  assign Dec_Start      = r_dec_start;
  assign Tx_Addr        = r_tx_addr;
  assign Tx_Data        = r_tx_data;
  assign Tx_Word_Strobe = r_tx_strobe;
  assign Progress_Flag  = r_progress;
  assign Tx_Start       = r_tx_start;
  assign CycleEndErr    = r_cyc_err;
  assign Active_Chan    = r_chan;
  assign Pkt_Cnt        = r_pkt_cnt;
  assign Err_Cnt        = r_err_cnt;

endmodule

// File: tb/tb_eth_pkt_dispatcher.sv
// tb/tb_eth_pkt_dispatcher.sv - randomized decoder-chain bench for eth_pkt_dispatcher
module tb_eth_pkt_dispatcher;

  localparam int N  = 3;
  localparam int AW = 11;
  localparam int DW = 16;

  logic            Clock = 1'b0;
  logic            Reset = 1'b0;
  logic            Rx_Parcer_RQ = 1'b0;
  logic [AW-1:0]   Rx_Addr_o;
  logic [N-1:0]    Dec_Start;
  logic [N*AW-1:0] Dec_Rx_Addr = '0;
  logic [N*AW-1:0] Dec_Tx_Addr = '0;
  logic [N*DW-1:0] Dec_Tx_Data = '0;
  logic [N-1:0]    Dec_Tx_Strobe = '0;
  logic [N-1:0]    Dec_Next = '0;
  logic [N-1:0]    Dec_Done = '0;
  logic [N-1:0]    Dec_Err = '0;
  logic [AW-1:0]   Tx_Addr;
  logic [DW-1:0]   Tx_Data;
  logic            Tx_Word_Strobe;
  logic            Progress_Flag;
  logic            Tx_Start;
  logic            CycleEndErr;
  logic            Timeout_Err;
  logic [2:0]      Active_Chan;
  logic [15:0]     Pkt_Cnt;
  logic [15:0]     Err_Cnt;

  always #5 Clock = ~Clock;

  eth_pkt_dispatcher #(.N_DEC(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(16)) dut (
    .Clock(Clock), .Reset(Reset), .Rx_Parcer_RQ(Rx_Parcer_RQ), .Rx_Addr_o(Rx_Addr_o),
    .Dec_Start(Dec_Start), .Dec_Rx_Addr(Dec_Rx_Addr), .Dec_Tx_Addr(Dec_Tx_Addr),
    .Dec_Tx_Data(Dec_Tx_Data), .Dec_Tx_Strobe(Dec_Tx_Strobe), .Dec_Next(Dec_Next),
    .Dec_Done(Dec_Done), .Dec_Err(Dec_Err), .Tx_Addr(Tx_Addr), .Tx_Data(Tx_Data),
    .Tx_Word_Strobe(Tx_Word_Strobe), .Progress_Flag(Progress_Flag), .Tx_Start(Tx_Start),
    .CycleEndErr(CycleEndErr), .Timeout_Err(Timeout_Err), .Active_Chan(Active_Chan),
    .Pkt_Cnt(Pkt_Cnt), .Err_Cnt(Err_Cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int exp_pkt = 0;
  int exp_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic clear_dec();
    Dec_Rx_Addr = '0; Dec_Tx_Addr = '0; Dec_Tx_Data = '0;
    Dec_Tx_Strobe = '0; Dec_Next = '0; Dec_Done = '0; Dec_Err = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dec_start"}, Dec_Start, 0);
    chk({tag, "_tx"}, {Tx_Word_Strobe, Tx_Addr, Tx_Data}, 0);
    chk({tag, "_pulses"}, {Tx_Start, CycleEndErr, Timeout_Err, Progress_Flag}, 0);
    chk({tag, "_chan"}, Active_Chan, 0);
    chk({tag, "_cnts"}, {Pkt_Cnt, Err_Cnt}, 0);
    chk({tag, "_rx_addr"}, Rx_Addr_o, 0);
  endtask

  // resp codes: 0 Next, 1 Done, 2 Err, 3 Err+Done; dly = RUN clocks before the flag
  task automatic run_packet(input int r0, input int r1, input int r2,
                            input int d0, input int d1, input int d2,
                            input bit noise, input bit dir);
    int resp[3];
    int dly[3];
    int seq[$];
    logic [AW+DW-1:0] expq[$];
    int dec = -1;
    bit exp_ok;
    int si = 0, cur = -1, cnt = 0, sidx = 0, n_ok = 0, n_err = 0;
    bit busy = 0, done = 0;
    logic [AW-1:0] a, rx;
    logic [DW-1:0] d;
    resp[0] = r0; resp[1] = r1; resp[2] = r2;
    dly[0] = d0;  dly[1] = d1;  dly[2] = d2;
    for (int k = 0; k < N; k++) begin
      if (dec < 0) begin
        seq.push_back(k);
        if (resp[k] != 0) dec = k;
      end
    end
    exp_ok = (dec >= 0) && (resp[dec] == 1);

    Rx_Parcer_RQ = 1'b1;
    step();
    Rx_Parcer_RQ = 1'b0;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      if (Tx_Word_Strobe) begin
        if (expq.size() == 0) chk("tx_unexpected", Tx_Word_Strobe, 0);
        else chk("tx_word", {Tx_Addr, Tx_Data}, expq.pop_front());
      end
      if (Dec_Start != 0) begin
        if (si < seq.size()) begin
          chk("dec_start", Dec_Start, 32'd1 << seq[si]);
          cur = seq[si]; si++; busy = 1; cnt = 0; sidx = 0;
        end else begin
          chk("dec_start_extra", Dec_Start, 0);
        end
      end
      if (Tx_Start) n_ok++;
      if (CycleEndErr) n_err++;
      if (Tx_Start || CycleEndErr) begin
        done = 1;
        chk("timeout_err_quiet", Timeout_Err, 0);
      end

      clear_dec();
      Rx_Parcer_RQ = noise && busy ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) begin
        for (int k = 0; k < N; k++) begin
          if (k != cur) begin
            Dec_Next[k] = 1'($urandom_range(0, 1));
            Dec_Done[k] = 1'($urandom_range(0, 1));
            Dec_Err[k] = 1'($urandom_range(0, 1));
            Dec_Tx_Strobe[k] = 1'($urandom_range(0, 1));
            Dec_Tx_Addr[k*AW +: AW] = AW'($urandom);
            Dec_Tx_Data[k*DW +: DW] = DW'($urandom);
            Dec_Rx_Addr[k*AW +: AW] = AW'($urandom);
          end
        end
      end
      if (busy) begin
        chk("active_chan", Active_Chan, cur);
        chk("progress_busy", Progress_Flag, 1);
        rx = AW'($urandom);
        Dec_Rx_Addr[cur*AW +: AW] = rx;
        if (dir || $urandom_range(0, 1) == 1) begin
          a = dir ? AW'(11'h010 + sidx) : AW'($urandom);
          d = DW'($urandom);
          Dec_Tx_Strobe[cur] = 1'b1;
          Dec_Tx_Addr[cur*AW +: AW] = a;
          Dec_Tx_Data[cur*DW +: DW] = d;
          expq.push_back({a, d});
          sidx++;
        end
        if (cnt == dly[cur] + 1) begin
          Dec_Next[cur] = (resp[cur] == 0);
          Dec_Done[cur] = (resp[cur] == 1) || (resp[cur] == 3);
          Dec_Err[cur]  = (resp[cur] == 2) || (resp[cur] == 3);
          busy = 0;
        end
        cnt++;
        #1;
        chk("rx_addr", Rx_Addr_o, rx);
      end
      if (!done) step();
    end

    if (exp_ok) begin
      if (exp_pkt < 65535) exp_pkt++;
    end else if (exp_err < 65535) begin
      exp_err++;
    end
    chk("pkt_finished", done, 1);
    chk("starts_seen", si, seq.size());
    chk("tx_start_cnt", n_ok, exp_ok ? 1 : 0);
    chk("cycle_err_cnt", n_err, exp_ok ? 0 : 1);
    chk("pkt_cnt", Pkt_Cnt, exp_pkt);
    chk("err_cnt", Err_Cnt, exp_err);
    chk("tx_missing", expq.size(), 0);
    clear_dec();
    Rx_Parcer_RQ = 1'b0;
    step();
    chk("progress_after", Progress_Flag, 0);
    chk("no_requeue", Dec_Start, 0);
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL sim_watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    Reset = 1'b0;
    step(); step();
    chk_all_zero("reset");
    Reset = 1'b1;
    step();

    // ch0 Next, ch1 Done with four strobes at 0x010..0x013
    run_packet(0, 1, 0, 0, 2, 0, 0, 1);
    // everyone passes
    run_packet(0, 0, 0, 1, 0, 2, 0, 0);
    // ch0 owns it while ch1 chatters; then ch0 Err+Done together
    run_packet(1, 0, 0, 3, 0, 0, 1, 0);
    run_packet(3, 0, 0, 1, 0, 0, 1, 0);
    // ch2 rejects
    run_packet(0, 0, 2, 0, 0, 0, 0, 0);

    for (int p = 0; p < 30; p++) begin
      int rr[3];
      for (int k = 0; k < 3; k++) begin
        rr[k] = $urandom_range(0, 5);
        rr[k] = (rr[k] <= 2) ? 0 : rr[k] - 2;
      end
      run_packet(rr[0], rr[1], rr[2], $urandom_range(0, 4), $urandom_range(0, 4),
                 $urandom_range(0, 4), 1'($urandom_range(0, 1)), 0);
    end

    // silent decoder
    Rx_Parcer_RQ = 1'b1;
    step();
    Rx_Parcer_RQ = 1'b0;
`ifdef ETH_DISP_TIMEOUT_EN
    cnt = 0;
    for (int i = 0; i < 40 && !CycleEndErr; i++) begin
      step();
      cnt++;
    end
    chk("timeout_latency", cnt, 17);
    chk("timeout_err", Timeout_Err, 1);
    exp_err++;
    chk("timeout_err_cnt", Err_Cnt, exp_err);
    step();
    chk("timeout_progress_after", Progress_Flag, 0);
`else
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (Progress_Flag && !CycleEndErr && !Timeout_Err) cnt++;
    end
    chk("no_watchdog_wait", cnt, 100);
`endif

    // abort mid-RUN with strobes active
    Rx_Parcer_RQ = 1'b1;
    step();
    Rx_Parcer_RQ = 1'b0;
    for (int i = 0; i < 3; i++) begin
      Dec_Tx_Strobe = '1;
      Dec_Tx_Addr = '1;
      Dec_Tx_Data = '1;
      step();
    end
    Reset = 1'b0;
    step();
    chk_all_zero("abort");
    Reset = 1'b1;
    clear_dec();
    exp_pkt = 0;
    exp_err = 0;
    step();
    chk("abort_no_pulse", {Tx_Start, CycleEndErr, Progress_Flag}, 0);

    run_packet(0, 1, 0, 1, 1, 0, 0, 0);

    // saturation of the reply counter
    force dut.r_pkt_cnt = 16'hFFFF;
    step();
    release dut.r_pkt_cnt;
    exp_pkt = 65535;
    chk("pkt_cnt_preset", Pkt_Cnt, 16'hFFFF);
    run_packet(1, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/eth_pkt_dispatcher.md
ETH_PKT_DISPATCHER -- requirements
Module: eth_pkt_dispatcher

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  N_DEC  3  number of chained decoder channels, 2..8
  ADDR_W  11  buffer address width
  DATA_W  16  buffer word width
  TIMEOUT_CYC  4096  watchdog limit in clocks, power of two, >=16
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  Clock  in  1  system clock (bus clock)
  Reset  in  1  synchronous, active-low reset
  Rx_Parcer_RQ  in  1  packet-ready pulse from Rx buffer
  Rx_Addr_o  out  ADDR_W  Rx buffer read address
  Dec_Start  out  N_DEC  one-hot start pulse to a channel
  Dec_Rx_Addr  in  N_DEC*ADDR_W  per-channel Rx read address, channel k at bits [k*ADDR_W +: ADDR_W]
  Dec_Tx_Addr  in  N_DEC*ADDR_W  per-channel Tx write address
  Dec_Tx_Data  in  N_DEC*DATA_W  per-channel Tx write data
  Dec_Tx_Strobe  in  N_DEC  per-channel Tx write strobe
  Dec_Next  in  N_DEC  channel does not own packet; pass on
  Dec_Done  in  N_DEC  channel consumed packet; reply ready in Tx buffer
  Dec_Err  in  N_DEC  channel rejected packet
  Tx_Addr  out  ADDR_W  registered Tx buffer address
  Tx_Data  out  DATA_W  registered Tx buffer data
  Tx_Word_Strobe  out  1  registered Tx write strobe
  Progress_Flag  out  1  parse cycle in progress
  Tx_Start  out  1  one-clock pulse: reply ready to send
  CycleEndErr  out  1  one-clock pulse: cycle ended in error
  Timeout_Err  out  1  one-clock pulse: watchdog expired
  Active_Chan  out  3  index of current channel
  Pkt_Cnt  out  16  replies produced, saturating
  Err_Cnt  out  16  error cycles, saturating

Function
REQ-003 FSM states SHALL be IDLE, START, RUN, END_OK, END_ERR; all outputs registered except Rx_Addr_o.
REQ-004 IDLE: Rx_Parcer_RQ=1 -> START with Active_Chan=0; Rx_Parcer_RQ in any other state SHALL be ignored, not queued.
REQ-005 START: Dec_Start[Active_Chan]=1 for exactly one clock -> RUN; all other Dec_Start bits 0.
REQ-006 RUN: only active channel's Dec_Err/Dec_Done/Dec_Next SHALL be sampled, priority Err > Done > Next; inactive channels' flags ignored.
REQ-007 RUN: Err -> END_ERR; Done -> END_OK; Next with Active_Chan<N_DEC-1 -> Active_Chan+1, START; Next with Active_Chan=N_DEC-1 -> END_ERR (unclaimed packet).
REQ-008 END_OK: Tx_Start=1 one clock, Pkt_Cnt+1 (hold at 0xFFFF) -> IDLE.
REQ-009 END_ERR: CycleEndErr=1 one clock, Err_Cnt+1 (hold at 0xFFFF) -> IDLE.
REQ-010 Progress_Flag SHALL be 1 in every state except IDLE; deasserts on the clock after END_*.
REQ-011 Rx_Addr_o SHALL combinationally select active channel's Dec_Rx_Addr in START/RUN, 0 otherwise.
REQ-012 Tx_Addr/Tx_Data/Tx_Word_Strobe SHALL register active channel's Tx signals with 1-clock latency in START/RUN; in other states next value is 0; inactive channels' strobes SHALL never reach output.
REQ-013 Tx write strobed in same clock as Dec_Done SHALL still be forwarded.

Reset
REQ-014 Reset=0 at a rising Clock edge SHALL force IDLE, Active_Chan=0, all pulse outputs, Tx outputs, Progress_Flag, counters and watchdog to 0, including mid-cycle; no Tx_Start or CycleEndErr pulse SHALL result from abort.

Configuration
REQ-015 Macro ETH_DISP_TIMEOUT_EN defined: watchdog counter cleared in START, increments each RUN clock; reaching TIMEOUT_CYC-1 in RUN with no flag -> END_ERR with Timeout_Err=1 same clock as CycleEndErr; a flag on that same clock wins over timeout.
REQ-016 Macro undefined: no watchdog logic; Timeout_Err tied 0; RUN waits indefinitely.

Verification (N_DEC=3, TIMEOUT_CYC=16)
REQ-017 RQ pulse; ch0 Next, ch1 Done with 4 strobes at addr 0x010..0x013 -> Dec_Start 001 then 010, Tx_Addr 0x010..0x013 one clock later, Tx_Start once, Pkt_Cnt=1.
REQ-018 ch0, ch1, ch2 each assert Next -> CycleEndErr once, Err_Cnt=1, Tx_Start never, Progress_Flag 0 after.
REQ-019 ch1 asserts Err and Done while ch0 active and Done -> END_OK via ch0; ch1 flags and strobes ignored; ch0 Err+Done same clock -> END_ERR.
REQ-020 Macro defined, no channel responds -> Timeout_Err and CycleEndErr on RUN clock 15; macro undefined -> Progress_Flag stays 1 for 100 clocks.
REQ-021 Reset=0 mid-RUN with strobes active -> next clock all outputs 0, IDLE; subsequent RQ processes normally; Pkt_Cnt preset 0xFFFF + Done -> stays 0xFFFF.
